// File: rtl/aes_encrypt_iter_ctrl.sv
// Iterative AES-128 encryptor, one round per cycle: out_valid rises 10 edges after accept, in_ready low while busy.
// Result is held until out_ready; define AES_CTRL_B2B_EN to accept the next block in the same cycle the result is taken.
module aes_encrypt_iter_ctrl #(
  parameter int ROUNDS = 10,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     plaintext,
  input  logic [127:0]     key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     ciphertext,
  output logic             busy,
  output logic [CNT_W-1:0] round_idx
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINAL = 2'd2, DONE = 2'd3} state_t;

  localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(ROUNDS - 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n sits at bits [127-8n -: 8]; row = n%4, column = n/4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = SBOX[s[127-8*(4*((c+w)%4)+w) -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input int i);
    case (i)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [ROUNDS:0][127:0] expand(input logic [127:0] k0);
    logic [ROUNDS:0][127:0] r;
    r[0] = k0;
    for (int i = 1; i <= ROUNDS; i++) r[i] = next_key(r[i-1], rcon(i));
    return r;
  endfunction

  state_t                 state, nxt;
  logic [CNT_W-1:0]       round;
  logic [127:0]           state_reg, key_reg;
  logic [ROUNDS:0][127:0] subkey;
  logic [127:0]           round_f, final_f;
  logic                   accept;

  // Whole schedule hangs off key_reg, so key port changes never reach an in-flight block.
  assign subkey  = expand(key_reg);
  assign round_f = mix_cols(sub_shift(state_reg)) ^ subkey[round];
  assign final_f = sub_shift(state_reg) ^ subkey[ROUNDS];

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = RUN;
      end
      RUN:   if (round == LAST_RUN) nxt = FINAL;
      FINAL: nxt = DONE;
      DONE: begin
`ifdef AES_CTRL_B2B_EN
        in_ready = out_ready;
        if (out_ready) nxt = in_valid ? RUN : IDLE;
`else
        if (out_ready) nxt = IDLE;
`endif
      end
      default: nxt = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign busy      = (state != IDLE);
  assign round_idx = round;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      round      <= '0;
      state_reg  <= '0;
      key_reg    <= '0;
      ciphertext <= '0;
      out_valid  <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        RUN: begin
          state_reg <= round_f;
          round     <= round + CNT_W'(1);
        end
        FINAL: begin
          ciphertext <= final_f;
          out_valid  <= 1'b1;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          round     <= '0;
        end
        default: ;
      endcase
      // An accept in DONE overrides the round clear above.
      if (accept) begin
        state_reg <= plaintext ^ key;
        key_reg   <= key;
        round     <= CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter_ctrl.sv
// Randomised and directed bench for aes_encrypt_iter_ctrl against a cycle-level behavioural model with its own AES.
module tb_aes_encrypt_iter_ctrl;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] plaintext = '0, key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] ciphertext;
  logic [3:0]   round_idx;

  aes_encrypt_iter_ctrl #(.ROUNDS(10), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy), .round_idx(round_idx)
  );

  always #5 clk = ~clk;

`ifdef AES_CTRL_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference AES from field arithmetic ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   rc;
    logic [31:0]  tw;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]};
        tw[31:24] = tw[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < 10)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
    end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  // ---------------- cycle model: busy for 11 edges, then hold result ----------------
  bit           chk_en = 1'b0;
  bit           m_busy = 1'b0, m_ov = 1'b0, acc;
  int           m_r = 0;
  logic [127:0] m_ct = '0, m_pend = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_ov = 1'b0; m_r = 0; m_ct = '0;
      chk_en = 1'b1;
    end else begin
      acc = in_valid && (!m_busy || (B2B && m_ov && out_ready));
      if (m_ov) begin
        if (out_ready) begin m_ov = 1'b0; m_busy = 1'b0; m_r = 0; end
      end else if (m_busy) begin
        if (m_r == 10) begin m_ov = 1'b1; m_ct = m_pend; end
        else m_r++;
      end
      if (acc) begin
        m_busy = 1'b1; m_r = 1; m_pend = aes_model(plaintext, key);
      end
    end
  end

  // Observed handshakes, stamped with the edge number they occurred on.
  int           cyc = 0;
  int           acc_q[$];
  logic [127:0] out_q[$];

  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    if (rst_n && out_valid && out_ready) out_q.push_back(ciphertext);
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("busy", 128'(busy), 128'(m_busy));
      chk("out_valid", 128'(out_valid), 128'(m_ov));
      chk("round_idx", 128'(round_idx), 128'(m_busy ? m_r : 0));
      chk("in_ready", 128'(in_ready), 128'(!m_busy || (B2B && m_ov && out_ready)));
      chk("ciphertext", ciphertext, m_ct);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] p, input logic [127:0] k);
    int n0;
    n0 = acc_q.size();
    plaintext = p; key = k; in_valid = 1'b1;
    for (int i = 0; i < 40 && acc_q.size() == n0; i++) tick();
    in_valid = 1'b0;
    chk("accepted", 128'(acc_q.size() > n0), 128'(1));
  endtask

  task automatic wait_ov(output int lat);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    chk("out_valid_rise", 128'(out_valid), 128'(1));
    lat = cyc - acc_q[$];
  endtask

  int lat, na, no, sp;

  initial begin
    build_sbox();
    chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
    chk("model_c1", aes_model(P1, K1), C1);
    chk("model_b", aes_model(P2, K2), C2);

    // Reset, then idle
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_round_idx", 128'(round_idx), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // C.1 with out_ready high: round_idx walks 1..10, result 10 edges after accept
    out_ready = 1'b1;
    send(P1, K1);
    for (int j = 1; j <= 10; j++) begin
      chk("c1_round_step", 128'(round_idx), 128'(j));
      tick();
    end
    chk("c1_out_valid", 128'(out_valid), 128'(1));
    chk("c1_latency", 128'(cyc - acc_q[$]), 128'(10));
    chk("c1_ct", ciphertext, C1);
    tick();
    chk("c1_out_valid_cleared", 128'(out_valid), 128'(0));

    // B with the consumer stalling 5 cycles
    out_ready = 1'b0;
    send(P2, K2);
    wait_ov(lat);
    chk("b_latency", 128'(lat), 128'(10));
    for (int j = 0; j < 5; j++) begin
      chk("b_ct_held", ciphertext, C2);
      chk("b_in_ready_low", 128'(in_ready), 128'(0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("b_handshake", out_q[$], C2);
    chk("b_ct_kept", ciphertext, C2);

    // Second pair offered while busy, key port disturbed mid-block
    out_ready = 1'b0;
    send(P1, K1);
    na = acc_q.size();
    plaintext = P2; key = K2; in_valid = 1'b1;
    for (int j = 0; j < 12 && round_idx != 4'd4; j++) tick();
    chk("busy_at_round4", 128'(round_idx), 128'(4));
    key = ~K1;
    chk("busy_in_ready", 128'(in_ready), 128'(0));
    wait_ov(lat);
    chk("busy_ct", ciphertext, C1);
    chk("busy_no_accept", 128'(acc_q.size()), 128'(na));
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    chk("busy_done", 128'(out_valid), 128'(0));

    // Reset pulse in the middle of a block
    send(P1, K1);
    for (int j = 0; j < 20 && round_idx != 4'd5; j++) tick();
    chk("rst_at_round5", 128'(round_idx), 128'(5));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_ct", ciphertext, 128'(0));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    no = out_q.size();
    repeat (15) tick();
    chk("midrst_no_output", 128'(out_q.size()), 128'(no));
    send(P1, K1);
    wait_ov(lat);
    chk("midrst_fresh_ct", ciphertext, C1);
    tick();

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    na = acc_q.size();
    no = out_q.size();
    plaintext = P1; key = K1; in_valid = 1'b1;
    for (int j = 0; j < 40 && acc_q.size() == na; j++) tick();
    plaintext = P2; key = K2;
    for (int j = 0; j < 40 && acc_q.size() < na + 2; j++) tick();
    in_valid = 1'b0;
    sp = (acc_q.size() >= na + 2) ? acc_q[na+1] - acc_q[na] : -1;
    chk("b2b_spacing", 128'(sp), B2B ? 128'(11) : 128'(12));
    for (int j = 0; j < 40 && out_q.size() < no + 2; j++) tick();
    chk("b2b_outputs", 128'(out_q.size()), 128'(no + 2));
    if (out_q.size() >= no + 2) begin
      chk("b2b_ct1", out_q[no], C1);
      chk("b2b_ct2", out_q[no+1], C2);
    end

    // Random traffic: in_valid held until accepted, random stalls and resets
    na = acc_q.size();
    for (int i = 0; i < 800; i++) begin
      if (!(in_valid && acc_q.size() == na)) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        key       = {$urandom, $urandom, $urandom, $urandom};
        na        = acc_q.size();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
